// File: rtl/clk_div_gen.sv
// Multi-channel programmable clock/strobe generator. Each channel divides clk with its own
// period, high time and start phase; new config is held in a shadow and applied at period wraps.
module clk_div_gen #(
  parameter int N_CH       = 4,
  parameter int CNT_W      = 16,
  parameter int DEF_PERIOD = 100
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [N_CH-1:0]                      en,
  input  logic                                 cfg_load,
  input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] cfg_sel,
  input  logic [CNT_W-1:0]                     cfg_period,
  input  logic [CNT_W-1:0]                     cfg_high,
  input  logic [CNT_W-1:0]                     cfg_phase,
  output logic [N_CH-1:0]                      clk_out,
  output logic [N_CH-1:0]                      tick,
  output logic [N_CH-1:0]                      running,
  output logic [N_CH-1:0]                      cfg_pend
);

  localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

  typedef struct packed {
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high;
    logic [CNT_W-1:0] phase;
  } cfg_t;

  localparam cfg_t DEF_CFG = {CNT_W'(DEF_PERIOD), CNT_W'(DEF_PERIOD / 2), {CNT_W{1'b0}}};

  // Force a raw request into a shape that always toggles: P >= 2, 1 <= H <= P-1, PH < P.
  function automatic cfg_t clamp_cfg(input cfg_t raw);
    cfg_t c;
    c.period = (raw.period < CNT_W'(2)) ? CNT_W'(2) : raw.period;
    if (raw.high == '0)
      c.high = CNT_W'(1);
    else if (raw.high > c.period - CNT_W'(1))
      c.high = c.period - CNT_W'(1);
    else
      c.high = raw.high;
    c.phase = (raw.phase < c.period) ? raw.phase : '0;
    return c;
  endfunction

  cfg_t load_cfg;
  assign load_cfg = {cfg_period, cfg_high, cfg_phase};

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      state_t           state_reg, state_next;
      logic [CNT_W-1:0] cnt_reg, cnt_next;
      cfg_t             act_reg, act_next;
      cfg_t             shadow_reg, shadow_next;
      logic             pend_reg, pend_next;
      logic             clk_out_reg, tick_reg, running_reg;
      logic             load_hit;
      logic             run_next;

      // Selects that do not name an existing channel simply never match.
      assign load_hit = cfg_load && (cfg_sel == SEL_W'(gi));

      always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        act_next    = act_reg;
        shadow_next = shadow_reg;
        pend_next   = pend_reg;
        case (state_reg)
          IDLE: begin
            if (load_hit) begin
              shadow_next = load_cfg;
              act_next    = clamp_cfg(load_cfg);
            end
            pend_next = 1'b0;
            if (en[gi]) begin
              state_next = RUN;
              cnt_next   = act_next.phase;
            end
          end
          default: begin
            if (cnt_reg == act_reg.period - CNT_W'(1)) begin
              cnt_next   = '0;
              state_next = en[gi] ? RUN : IDLE;
              if (pend_reg) begin
                act_next  = clamp_cfg(shadow_reg);
                pend_next = 1'b0;
              end
            end else begin
              cnt_next   = cnt_reg + CNT_W'(1);
              state_next = en[gi] ? RUN : STOPPING;
            end
            // A load on the wrap edge misses this wrap and waits for the next one.
            if (load_hit) begin
              shadow_next = load_cfg;
              pend_next   = 1'b1;
            end
            // Stopping on this edge: nothing left to wait for, take the load now.
            if (state_next == IDLE && load_hit) begin
              act_next  = clamp_cfg(load_cfg);
              pend_next = 1'b0;
            end
          end
        endcase
        run_next = (state_next != IDLE);
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          state_reg   <= IDLE;
          cnt_reg     <= '0;
          act_reg     <= DEF_CFG;
          shadow_reg  <= DEF_CFG;
          pend_reg    <= 1'b0;
          clk_out_reg <= 1'b0;
          tick_reg    <= 1'b0;
          running_reg <= 1'b0;
        end else begin
          state_reg   <= state_next;
          cnt_reg     <= cnt_next;
          act_reg     <= act_next;
          shadow_reg  <= shadow_next;
          pend_reg    <= pend_next;
          clk_out_reg <= run_next && (cnt_next < act_next.high);
          tick_reg    <= run_next && (cnt_next == '0);
          running_reg <= run_next;
        end
      end

      assign clk_out[gi]  = clk_out_reg;
      assign tick[gi]     = tick_reg;
      assign running[gi]  = running_reg;
      assign cfg_pend[gi] = pend_reg;
    end
  endgenerate

endmodule

// File: tb/tb_clk_div_gen.sv
// Directed bench for clk_div_gen: defaults, clamping, phase, boundary reconfig, glitch-free stop
// and mid-run reset, with expected waveforms derived from cycle indices.
module tb_clk_div_gen;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  en;
  logic        cfg_load;
  logic [1:0]  cfg_sel;
  logic [15:0] cfg_period, cfg_high, cfg_phase;
  logic [3:0]  clk_out, tick, running, cfg_pend;

  int n_checks = 0;
  int n_pass   = 0;

  clk_div_gen #(.N_CH(4), .CNT_W(16), .DEF_PERIOD(100)) dut (
    .clk(clk), .rst(rst), .en(en), .cfg_load(cfg_load), .cfg_sel(cfg_sel),
    .cfg_period(cfg_period), .cfg_high(cfg_high), .cfg_phase(cfg_phase),
    .clk_out(clk_out), .tick(tick), .running(running), .cfg_pend(cfg_pend)
  );

  always #5 clk = ~clk;

  // Advance one edge; outputs are then sampled 1ns after it. Load strobes last one edge.
  task automatic step();
    @(posedge clk);
    #1;
    cfg_load = 1'b0;
  endtask

  task automatic drive_load(input logic [1:0] sel, input int p, input int h, input int ph);
    cfg_load   = 1'b1;
    cfg_sel    = sel;
    cfg_period = 16'(p);
    cfg_high   = 16'(h);
    cfg_phase  = 16'(ph);
  endtask

  task automatic do_reset();
    rst = 1'b1; en = '0; cfg_load = 1'b0; cfg_sel = '0;
    cfg_period = '0; cfg_high = '0; cfg_phase = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (clk_out !== 4'b0) $display("FAIL reset_clk_out got %b exp 0000", clk_out); else n_pass++;
    n_checks++; if (tick !== 4'b0) $display("FAIL reset_tick got %b exp 0000", tick); else n_pass++;
    n_checks++; if (running !== 4'b0) $display("FAIL reset_running got %b exp 0000", running); else n_pass++;
    n_checks++; if (cfg_pend !== 4'b0) $display("FAIL reset_cfg_pend got %b exp 0000", cfg_pend); else n_pass++;
    $display("test_reset done: %0d/%0d", n_pass, n_checks);
  endtask

  task automatic test_defaults();
    do_reset();
    en[0] = 1'b1;
    step();
    for (int k = 0; k < 250; k++) begin
      n_checks++; if (running[0] !== 1'b1) $display("FAIL dflt_running k=%0d got %b exp 1", k, running[0]); else n_pass++;
      n_checks++; if (clk_out[0] !== ((k % 100) < 50)) $display("FAIL dflt_clk k=%0d got %b exp %b", k, clk_out[0], (k % 100) < 50); else n_pass++;
      n_checks++; if (tick[0] !== ((k % 100) == 0)) $display("FAIL dflt_tick k=%0d got %b exp %b", k, tick[0], (k % 100) == 0); else n_pass++;
      step();
    end
    $display("test_defaults done: %0d/%0d", n_pass, n_checks);
  endtask

  task automatic test_clamp();
    do_reset();
    drive_load(2'd1, 1, 5, 0);
    step();
    n_checks++; if (cfg_pend[1] !== 1'b0) $display("FAIL clamp_idle_pend got %b exp 0", cfg_pend[1]); else n_pass++;
    en[1] = 1'b1;
    step();
    for (int k = 0; k < 12; k++) begin
      n_checks++; if (clk_out[1] !== ((k % 2) == 0)) $display("FAIL clamp_p2_clk k=%0d got %b exp %b", k, clk_out[1], (k % 2) == 0); else n_pass++;
      n_checks++; if (tick[1] !== ((k % 2) == 0)) $display("FAIL clamp_p2_tick k=%0d got %b exp %b", k, tick[1], (k % 2) == 0); else n_pass++;
      step();
    end
    do_reset();
    drive_load(2'd1, 10, 0, 0);
    step();
    en[1] = 1'b1;
    step();
    for (int k = 0; k < 25; k++) begin
      n_checks++; if (clk_out[1] !== ((k % 10) == 0)) $display("FAIL clamp_h0_clk k=%0d got %b exp %b", k, clk_out[1], (k % 10) == 0); else n_pass++;
      step();
    end
    $display("test_clamp done: %0d/%0d", n_pass, n_checks);
  endtask

  task automatic test_phase();
    do_reset();
    drive_load(2'd2, 8, 4, 0);
    step();
    drive_load(2'd3, 8, 4, 4);
    step();
    en[2] = 1'b1; en[3] = 1'b1;
    step();
    for (int k = 0; k < 24; k++) begin
      n_checks++; if (clk_out[2] !== ((k % 8) < 4)) $display("FAIL phase_ch2_clk k=%0d got %b exp %b", k, clk_out[2], (k % 8) < 4); else n_pass++;
      n_checks++; if (clk_out[3] !== ((k % 8) >= 4)) $display("FAIL phase_ch3_clk k=%0d got %b exp %b", k, clk_out[3], (k % 8) >= 4); else n_pass++;
      n_checks++; if (tick[3] !== ((k % 8) == 4)) $display("FAIL phase_ch3_tick k=%0d got %b exp %b", k, tick[3], (k % 8) == 4); else n_pass++;
      step();
    end
    $display("test_phase done: %0d/%0d", n_pass, n_checks);
  endtask

  task automatic test_reconfig();
    logic exp_clk, exp_tick;
    // Part 1: load on the edge that makes cnt=3; ch1 runs alongside with its own config.
    do_reset();
    drive_load(2'd0, 10, 5, 0);
    step();
    drive_load(2'd1, 8, 4, 0);
    step();
    en[0] = 1'b1; en[1] = 1'b1;
    step();
    for (int k = 0; k < 34; k++) begin
      if (k < 10) begin
        exp_clk = (k < 5); exp_tick = (k == 0);
      end else begin
        exp_clk = (((k - 10) % 6) < 3); exp_tick = (((k - 10) % 6) == 0);
      end
      n_checks++; if (clk_out[0] !== exp_clk) $display("FAIL reconf_clk k=%0d got %b exp %b", k, clk_out[0], exp_clk); else n_pass++;
      n_checks++; if (tick[0] !== exp_tick) $display("FAIL reconf_tick k=%0d got %b exp %b", k, tick[0], exp_tick); else n_pass++;
      n_checks++; if (cfg_pend[0] !== (k >= 3 && k < 10)) $display("FAIL reconf_pend k=%0d got %b exp %b", k, cfg_pend[0], k >= 3 && k < 10); else n_pass++;
      n_checks++; if (clk_out[1] !== ((k % 8) < 4)) $display("FAIL reconf_ch1_clk k=%0d got %b exp %b", k, clk_out[1], (k % 8) < 4); else n_pass++;
      n_checks++; if (cfg_pend[1] !== 1'b0) $display("FAIL reconf_ch1_pend k=%0d got %b exp 0", k, cfg_pend[1]); else n_pass++;
      if (k == 2) drive_load(2'd0, 6, 3, 0);
      step();
    end
    // Part 2: load coincident with cnt=9, then overwritten while pending.
    do_reset();
    drive_load(2'd0, 10, 5, 0);
    step();
    en[0] = 1'b1;
    step();
    for (int k = 0; k < 40; k++) begin
      if (k < 20) begin
        exp_clk = ((k % 10) < 5); exp_tick = ((k % 10) == 0);
      end else begin
        exp_clk = (((k - 20) % 4) < 1); exp_tick = (((k - 20) % 4) == 0);
      end
      n_checks++; if (clk_out[0] !== exp_clk) $display("FAIL wrapload_clk k=%0d got %b exp %b", k, clk_out[0], exp_clk); else n_pass++;
      n_checks++; if (tick[0] !== exp_tick) $display("FAIL wrapload_tick k=%0d got %b exp %b", k, tick[0], exp_tick); else n_pass++;
      n_checks++; if (cfg_pend[0] !== (k >= 10 && k < 20)) $display("FAIL wrapload_pend k=%0d got %b exp %b", k, cfg_pend[0], k >= 10 && k < 20); else n_pass++;
      if (k == 9)  drive_load(2'd0, 6, 3, 0);
      if (k == 14) drive_load(2'd0, 4, 1, 0);
      step();
    end
    $display("test_reconfig done: %0d/%0d", n_pass, n_checks);
  endtask

  task automatic test_stop();
    // Deassert at cnt=2: the period is finished cleanly, then the channel idles.
    do_reset();
    drive_load(2'd0, 10, 5, 0);
    step();
    en[0] = 1'b1;
    step();
    for (int k = 0; k < 16; k++) begin
      n_checks++; if (clk_out[0] !== (k < 5)) $display("FAIL stop_clk k=%0d got %b exp %b", k, clk_out[0], k < 5); else n_pass++;
      n_checks++; if (running[0] !== (k < 10)) $display("FAIL stop_running k=%0d got %b exp %b", k, running[0], k < 10); else n_pass++;
      n_checks++; if (tick[0] !== (k == 0)) $display("FAIL stop_tick k=%0d got %b exp %b", k, tick[0], k == 0); else n_pass++;
      if (k == 2) en[0] = 1'b0;
      step();
    end
    // Deassert at cnt=2, reassert at cnt=7: waveform must be undisturbed.
    do_reset();
    drive_load(2'd0, 10, 5, 0);
    step();
    en[0] = 1'b1;
    step();
    for (int k = 0; k < 26; k++) begin
      n_checks++; if (clk_out[0] !== ((k % 10) < 5)) $display("FAIL restart_clk k=%0d got %b exp %b", k, clk_out[0], (k % 10) < 5); else n_pass++;
      n_checks++; if (tick[0] !== ((k % 10) == 0)) $display("FAIL restart_tick k=%0d got %b exp %b", k, tick[0], (k % 10) == 0); else n_pass++;
      n_checks++; if (running[0] !== 1'b1) $display("FAIL restart_running k=%0d got %b exp 1", k, running[0]); else n_pass++;
      if (k == 2) en[0] = 1'b0;
      if (k == 7) en[0] = 1'b1;
      step();
    end
    $display("test_stop done: %0d/%0d", n_pass, n_checks);
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive_load(2'd0, 10, 5, 0);
    step();
    en[0] = 1'b1;
    step();
    step();
    drive_load(2'd0, 6, 3, 0);
    step();
    n_checks++; if (cfg_pend[0] !== 1'b1) $display("FAIL rmid_pend_before got %b exp 1", cfg_pend[0]); else n_pass++;
    rst = 1'b1; en = '0;
    step();
    n_checks++; if (clk_out !== 4'b0) $display("FAIL rmid_clk_out got %b exp 0000", clk_out); else n_pass++;
    n_checks++; if (tick !== 4'b0) $display("FAIL rmid_tick got %b exp 0000", tick); else n_pass++;
    n_checks++; if (running !== 4'b0) $display("FAIL rmid_running got %b exp 0000", running); else n_pass++;
    n_checks++; if (cfg_pend !== 4'b0) $display("FAIL rmid_cfg_pend got %b exp 0000", cfg_pend); else n_pass++;
    rst = 1'b0;
    step();
    en[0] = 1'b1;
    step();
    for (int k = 0; k < 120; k++) begin
      n_checks++; if (clk_out[0] !== ((k % 100) < 50)) $display("FAIL rmid_clk k=%0d got %b exp %b", k, clk_out[0], (k % 100) < 50); else n_pass++;
      n_checks++; if (tick[0] !== ((k % 100) == 0)) $display("FAIL rmid_tick k=%0d got %b exp %b", k, tick[0], (k % 100) == 0); else n_pass++;
      step();
    end
    $display("test_reset_mid done: %0d/%0d", n_pass, n_checks);
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_clamp();
    test_phase();
    test_reconfig();
    test_stop();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
